ex_mdu: RTL and testbench
=========================

EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 16, 32 or 64.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports aluop_i input 8 and alusel_i input 3, encoded per the shared define file (EXE_*_OP, EXE_RES_*).
REQ-006 SHALL have ports reg1_i, reg2_i  input  WIDTH  operands.
REQ-007 SHALL have ports wd_i  input  REG_ADDR_W and wreg_i  input  1  destination address and write enable.
REQ-008 SHALL have port flush_i  input  1  aborts any in-flight divide.
REQ-009 SHALL have ports wd_o  output  REG_ADDR_W, wreg_o  output  1, wdata_o  output  WIDTH  GPR writeback.
REQ-010 SHALL have ports hi_o, lo_o  output  WIDTH  architectural HI/LO registers.
REQ-011 SHALL have port stallreq_o  output  1  high while a divide occupies the stage.

Function
REQ-012 SHALL compute, combinationally: AND/OR/XOR/NOR of reg1_i,reg2_i; SLL/SRL/SRA of reg2_i by reg1_i[log2(WIDTH)-1:0]; ADDU/SUBU modulo 2^WIDTH; SLT signed and SLTU unsigned (result 1 or 0).
REQ-013 SHALL select wdata_o by alusel_i: LOGIC, SHIFT, ARITH, MOVE (MFHI -> hi_o, MFLO -> lo_o); any other alusel_i -> zero.
REQ-014 SHALL pass wd_i, wreg_i to wd_o, wreg_o unchanged, except wreg_o forced 0 while stallreq_o is high.
REQ-015 SHALL on MULT (signed) / MULTU write the 2*WIDTH product into {HI,LO} at the next clk edge; single-cycle, no stall.
REQ-016 SHALL on MTHI/MTLO write reg1_i into HI/LO at the next clk edge.
REQ-017 SHALL implement DIV (signed) / DIVU with a 3-state FSM: IDLE, BUSY, DONE.
REQ-018 IDLE -> BUSY on clk edge when aluop_i is DIV/DIVU and flush_i=0; operands (magnitudes for DIV) latched.
REQ-019 BUSY SHALL run one restoring shift-subtract step per cycle, WIDTH steps; BUSY -> DONE after step WIDTH.
REQ-020 DONE SHALL write LO=quotient, HI=remainder at its clk edge and return to IDLE; total latency WIDTH+2 edges from issue.
REQ-021 stallreq_o SHALL be high combinationally in IDLE when a divide op is presented, and in BUSY; low in DONE.
REQ-022 Signed divide SHALL negate quotient when operand signs differ and give remainder the dividend's sign.
REQ-023 Divide-by-zero SHALL skip iteration: BUSY lasts one cycle, LO = all-ones, HI = dividend (raw reg1_i).
REQ-024 Most-negative / -1 signed divide SHALL yield LO = most-negative value, HI = 0.
REQ-025 flush_i=1 in any state SHALL force IDLE at next edge, no HI/LO write, stallreq_o low that cycle.
REQ-026 HI/LO writes SHALL have priority: divide DONE > MULT/MULTU > MTHI/MTLO; a lower-priority op presented in DONE is ignored.
REQ-027 MFHI/MFLO SHALL read the current registered HI/LO (no bypass of a same-edge write).

Reset
REQ-028 rst low SHALL asynchronously clear HI, LO, divider datapath and FSM to IDLE; stallreq_o, wreg_o, wdata_o, wd_o SHALL read 0 while rst is low.
REQ-029 Deasserting rst mid-divide SHALL leave the block in IDLE; the interrupted divide is lost.

Verification
REQ-030 OR 0x0000F0F0,0x0F0F0000, alusel LOGIC, wd=5, wreg=1 -> same cycle wdata_o=0x0F0FF0F0, wd_o=5, wreg_o=1.
REQ-031 MULT 0xFFFFFFFF(-1) x 0x00000002 -> next edge HI=0xFFFFFFFF, LO=0xFFFFFFFE; MFLO -> 0xFFFFFFFE.
REQ-032 DIV 0xFFFFFFF9(-7) / 2 -> stallreq_o high 33 cycles; edge 34 LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 DIVU 100 / 0 -> stallreq_o high 2 cycles; LO=0xFFFFFFFF, HI=0x00000064.
REQ-034 DIVU 100/7, flush_i pulsed at cycle 10 -> IDLE next edge, HI/LO unchanged, stallreq_o low.
REQ-035 rst low during BUSY -> HI=LO=0, stallreq_o=0 immediately, no clock required.

Source files
------------

// File: rtl/ex_mdu.sv
// Execute stage with ALU, HI/LO registers, single-cycle multiply and a
// restoring iterative divider that stalls the pipeline while it runs.
module ex_mdu #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            aluop_i,
    input  logic [2:0]            alusel_i,
    input  logic [WIDTH-1:0]      reg1_i,
    input  logic [WIDTH-1:0]      reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic [WIDTH-1:0]      hi_o,
    output logic [WIDTH-1:0]      lo_o,
    output logic                  stallreq_o
);

    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE       = 3'b011;
    localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = $clog2(WIDTH);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  divisor_q, divisor_d;
    logic              div_zero_q, div_zero_d;
    logic              quo_neg_q, quo_neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;

    logic [WIDTH-1:0]  logic_res, shift_res, arith_res, move_res, wdata;
    logic [SHW-1:0]    shamt;
    logic              slt_bit, sltu_bit;

    assign shamt    = reg1_i[SHW-1:0];
    assign slt_bit  = $signed(reg1_i) < $signed(reg2_i);
    assign sltu_bit = reg1_i < reg2_i;

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        move_res  = '0;
        case (aluop_i)
            EXE_AND_OP:  logic_res = reg1_i & reg2_i;
            EXE_OR_OP:   logic_res = reg1_i | reg2_i;
            EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
            EXE_SLL_OP:  shift_res = reg2_i << shamt;
            EXE_SRL_OP:  shift_res = reg2_i >> shamt;
            EXE_SRA_OP:  shift_res = $signed(reg2_i) >>> shamt;
            EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
            EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
            EXE_SLT_OP:  arith_res = {{(WIDTH-1){1'b0}}, slt_bit};
            EXE_SLTU_OP: arith_res = {{(WIDTH-1){1'b0}}, sltu_bit};
            EXE_MFHI_OP: move_res  = hi_q;
            EXE_MFLO_OP: move_res  = lo_q;
            default:     ;
        endcase
    end

    always_comb begin
        case (alusel_i)
            EXE_RES_LOGIC:      wdata = logic_res;
            EXE_RES_SHIFT:      wdata = shift_res;
            EXE_RES_ARITHMETIC: wdata = arith_res;
            EXE_RES_MOVE:       wdata = move_res;
            default:            wdata = '0;
        endcase
    end

    // Sign- or zero-extend to 2*WIDTH so one unsigned multiplier serves both.
    logic              is_mult, is_multu, mul_signed;
    logic [2*WIDTH-1:0] mul_a, mul_b, product;

    assign is_mult    = (aluop_i == EXE_MULT_OP);
    assign is_multu   = (aluop_i == EXE_MULTU_OP);
    assign mul_signed = is_mult;
    assign mul_a      = {{WIDTH{mul_signed & reg1_i[WIDTH-1]}}, reg1_i};
    assign mul_b      = {{WIDTH{mul_signed & reg2_i[WIDTH-1]}}, reg2_i};
    assign product    = mul_a * mul_b;

    logic              is_div, is_sdiv, op1_neg, op2_neg;
    logic [WIDTH-1:0]  op1_mag, op2_mag;
    logic [WIDTH:0]    partial, diff;
    logic [WIDTH-1:0]  div_quo, div_rem;
    logic              stall_div, div_wr;

    assign is_sdiv = (aluop_i == EXE_DIV_OP);
    assign is_div  = is_sdiv || (aluop_i == EXE_DIVU_OP);
    assign op1_neg = is_sdiv & reg1_i[WIDTH-1];
    assign op2_neg = is_sdiv & reg2_i[WIDTH-1];
    assign op1_mag = op1_neg ? -reg1_i : reg1_i;
    assign op2_mag = op2_neg ? -reg2_i : reg2_i;

    assign partial = {rem_q, quo_q[WIDTH-1]};
    assign diff    = partial - {1'b0, divisor_q};
    assign div_quo = quo_neg_q ? -quo_q : quo_q;
    assign div_rem = rem_neg_q ? -rem_q : rem_q;

    // On divide-by-zero the quotient register carries the raw dividend to HI.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        divisor_d  = divisor_q;
        div_zero_d = div_zero_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        stall_div  = 1'b0;
        div_wr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_div && !flush_i) begin
                    stall_div  = 1'b1;
                    state_d    = ST_BUSY;
                    cnt_d      = '0;
                    rem_d      = '0;
                    divisor_d  = op2_mag;
                    div_zero_d = (reg2_i == '0);
                    quo_d      = (reg2_i == '0) ? reg1_i : op1_mag;
                    quo_neg_d  = op1_neg ^ op2_neg;
                    rem_neg_d  = op1_neg;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (div_zero_q) begin
                    stall_div = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    stall_div = 1'b1;
                    rem_d     = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo_d     = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                    cnt_d     = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(WIDTH - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                div_wr  = !flush_i;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (!flush_i) begin
            if (div_wr) begin
                lo_d = div_zero_q ? '1 : div_quo;
                hi_d = div_zero_q ? quo_q : div_rem;
            end else if (state_q == ST_DONE) begin
                hi_d = hi_q;
            end else if (is_mult || is_multu) begin
                {hi_d, lo_d} = product;
            end else if (aluop_i == EXE_MTHI_OP) begin
                hi_d = reg1_i;
            end else if (aluop_i == EXE_MTLO_OP) begin
                lo_d = reg1_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            div_zero_q <= 1'b0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            divisor_q  <= divisor_d;
            div_zero_q <= div_zero_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // Writeback outputs read zero for as long as reset is held.
    assign stallreq_o = rst & stall_div;
    assign wreg_o     = rst & wreg_i & ~stall_div;
    assign wd_o       = rst ? wd_i : '0;
    assign wdata_o    = rst ? wdata : '0;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: stimulus pushes expected results into a
// scoreboard; a negedge monitor pops and compares them when they fall due.
module tb_ex_mdu;

    localparam logic [7:0] NOP   = 8'h00;
    localparam logic [7:0] AND_  = 8'b0010_0100;
    localparam logic [7:0] OR_   = 8'b0010_0101;
    localparam logic [7:0] XOR_  = 8'b0010_0110;
    localparam logic [7:0] NOR_  = 8'b0010_0111;
    localparam logic [7:0] SLL   = 8'b0111_1100;
    localparam logic [7:0] SRL   = 8'b0000_0010;
    localparam logic [7:0] SRA   = 8'b0000_0011;
    localparam logic [7:0] ADDU  = 8'b0010_0001;
    localparam logic [7:0] SUBU  = 8'b0010_0011;
    localparam logic [7:0] SLT   = 8'b0010_1010;
    localparam logic [7:0] SLTU  = 8'b0010_1011;
    localparam logic [7:0] MFHI  = 8'b0001_0000;
    localparam logic [7:0] MTHI  = 8'b0001_0001;
    localparam logic [7:0] MFLO  = 8'b0001_0010;
    localparam logic [7:0] MTLO  = 8'b0001_0011;
    localparam logic [7:0] MULT  = 8'b0001_1000;
    localparam logic [7:0] MULTU = 8'b0001_1001;
    localparam logic [7:0] DIV   = 8'b0001_1010;
    localparam logic [7:0] DIVU  = 8'b0001_1011;

    localparam logic [2:0] S_NOP = 3'b000;
    localparam logic [2:0] S_LOG = 3'b001;
    localparam logic [2:0] S_SHF = 3'b010;
    localparam logic [2:0] S_MOV = 3'b011;
    localparam logic [2:0] S_ARI = 3'b100;

    localparam int M_WDATA = 1, M_WD = 2, M_WREG = 4, M_HI = 8, M_LO = 16, M_ST = 32;
    localparam int M_ALL   = 63;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  aluop_i = '0;
    logic [2:0]  alusel_i = '0;
    logic [31:0] reg1_i = '0, reg2_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0, flush_i = 1'b0;
    logic [4:0]  wd_o;
    logic        wreg_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    ex_mdu #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        string       name;
        int          m;
        logic [31:0] wdata;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        stall;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic [31:0] model_hi = '0, model_lo = '0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h (cycle %0d)", nm, fld, act, exp, cyc);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                if (e.due < cyc) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL %s: sample slot %0d missed at cycle %0d", e.name, e.due, cyc);
                end else begin
                    if ((e.m & M_WDATA) != 0) chk(e.name, "wdata", wdata_o, e.wdata);
                    if ((e.m & M_WD)    != 0) chk(e.name, "wd", {27'd0, wd_o}, {27'd0, e.wd});
                    if ((e.m & M_WREG)  != 0) chk(e.name, "wreg", {31'd0, wreg_o}, {31'd0, e.wreg});
                    if ((e.m & M_HI)    != 0) chk(e.name, "hi", hi_o, e.hi);
                    if ((e.m & M_LO)    != 0) chk(e.name, "lo", lo_o, e.lo);
                    if ((e.m & M_ST)    != 0) chk(e.name, "stall", {31'd0, stallreq_o}, {31'd0, e.stall});
                    $display("check %s @%0d wdata=%08h hi=%08h lo=%08h stall=%0b", e.name, cyc, wdata_o, hi_o, lo_o, stallreq_o);
                end
            end
        end
    end

    task automatic push(input string nm, input int off, input int m, input logic [31:0] wdata,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] hi,
                        input logic [31:0] lo, input logic stall);
        exp_t e;
        e.due = cyc + off; e.name = nm; e.m = m; e.wdata = wdata; e.wd = wd;
        e.wreg = wreg; e.hi = hi; e.lo = lo; e.stall = stall;
        sb.push_back(e);
    endtask

    task automatic exp_hilo(input string nm, input int off, input logic [31:0] hi, input logic [31:0] lo);
        push(nm, off, M_HI | M_LO, '0, '0, 1'b0, hi, lo, 1'b0);
    endtask

    task automatic exp_stall(input string nm, input int off, input logic s);
        push(nm, off, M_ST, '0, '0, 1'b0, '0, '0, s);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wd, input logic wr);
        aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr;
    endtask

    task automatic alu(input string nm, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        set(op, sel, a, b, 5'd9, 1'b1);
        push(nm, 0, M_WDATA | M_WD | M_WREG | M_ST, exp, 5'd9, 1'b1, '0, '0, 1'b0);
        step();
    endtask

    // k = edge that leaves DONE; HI/LO change becomes visible in cycle k.
    task automatic run_div(input string nm, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input bit pri);
        int k;
        k = (b == 0) ? 3 : 34;
        set(op, S_NOP, a, b, 5'd3, 1'b1);
        push({nm, "_issue"}, 0, M_ST | M_WREG, '0, '0, 1'b0, '0, '0, 1'b1);
        exp_stall({nm, "_lastbusy"}, k - 2, 1'b1);
        exp_stall({nm, "_done"}, k - 1, 1'b0);
        exp_hilo({nm, "_hold"}, k - 1, model_hi, model_lo);
        exp_hilo({nm, "_result"}, k, exp_hi, exp_lo);
        repeat (k - 1) step();
        if (pri) begin
            aluop_i = MTLO;
            reg1_i  = 32'h0000_0055;
        end
        step();
        set(NOP, S_NOP, '0, '0, '0, 1'b0);
        exp_stall({nm, "_idle"}, 0, 1'b0);
        model_hi = exp_hi;
        model_lo = exp_lo;
        step();
    endtask

    initial begin : stim
        // Reset held: outputs gated even with a live OR op presented.
        set(OR_, S_LOG, 32'h0000_F0F0, 32'h0F0F_0000, 5'd5, 1'b1);
        step();
        push("reset", 0, M_ALL, '0, '0, 1'b0, '0, '0, 1'b0);
        step();
        rst = 1'b1;
        push("or", 0, M_WDATA | M_WD | M_WREG | M_ST, 32'h0F0F_F0F0, 5'd5, 1'b1, '0, '0, 1'b0);
        step();

        alu("and",  AND_, S_LOG, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
        alu("xor",  XOR_, S_LOG, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0);
        alu("nor",  NOR_, S_LOG, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h000F_000F);
        alu("sll",  SLL,  S_SHF, 32'h0000_0024, 32'h8000_000F, 32'h0000_00F0);
        alu("srl",  SRL,  S_SHF, 32'h0000_0024, 32'h8000_000F, 32'h0800_0000);
        alu("sra",  SRA,  S_SHF, 32'h0000_0024, 32'h8000_000F, 32'hF800_0000);
        alu("addu", ADDU, S_ARI, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
        alu("subu", SUBU, S_ARI, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF);
        alu("slt",  SLT,  S_ARI, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
        alu("sltu", SLTU, S_ARI, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000);
        alu("badsel", OR_, 3'b111, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_0000);

        set(MULT, S_NOP, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, 1'b0);
        exp_hilo("mult", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        step();
        alu("mflo", MFLO, S_MOV, '0, '0, 32'hFFFF_FFFE);
        set(MULTU, S_NOP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
        exp_hilo("multu", 1, 32'hFFFF_FFFE, 32'h0000_0001);
        step();
        set(MTHI, S_NOP, 32'hCAFE_BABE, '0, 5'd0, 1'b0);
        exp_hilo("mthi", 1, 32'hCAFE_BABE, 32'h0000_0001);
        step();
        set(MTLO, S_NOP, 32'h1357_9BDF, '0, 5'd0, 1'b0);
        exp_hilo("mtlo", 1, 32'hCAFE_BABE, 32'h1357_9BDF);
        step();
        alu("mfhi", MFHI, S_MOV, '0, '0, 32'hCAFE_BABE);
        alu("mflo2", MFLO, S_MOV, '0, '0, 32'h1357_9BDF);
        model_hi = 32'hCAFE_BABE;
        model_lo = 32'h1357_9BDF;

        run_div("div_m7_2", DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_div("divu_by0", DIVU, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0064, 1'b1);

        // Flush in the middle of a divide: nothing must ever be written.
        set(DIVU, S_NOP, 32'h0000_0064, 32'h0000_0007, 5'd3, 1'b1);
        exp_stall("flush_issue", 0, 1'b1);
        repeat (10) step();
        flush_i = 1'b1;
        exp_stall("flush_cycle", 0, 1'b0);
        step();
        flush_i = 1'b0;
        set(NOP, S_NOP, '0, '0, '0, 1'b0);
        exp_stall("flush_idle", 0, 1'b0);
        exp_hilo("flush_hold", 0, model_hi, model_lo);
        repeat (40) step();
        exp_hilo("flush_late", 0, model_hi, model_lo);
        step();

        run_div("div_7_m2", DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0);
        run_div("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
        run_div("divu_big", DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0);

        // Asynchronous reset while the divider is busy.
        set(DIV, S_LOG, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7, 1'b1);
        repeat (5) step();
        rst = 1'b0;
        push("rst_busy", 0, M_ALL, '0, '0, 1'b0, '0, '0, 1'b0);
        step();
        rst = 1'b1;
        set(NOP, S_NOP, '0, '0, '0, 1'b0);
        exp_stall("rst_idle", 0, 1'b0);
        repeat (40) step();
        exp_hilo("rst_lost", 0, '0, '0);

        repeat (3) step();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s: never sampled, due cycle %0d", e.name, e.due);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
